input_sampler: RTL and testbench
================================

INPUT_SAMPLER -- requirements
Module: input_sampler

Interface
- REQ-001 Parameter CLK_FREQUENCY, default 50000000: system clock frequency in Hz.
- REQ-002 Parameter SAMPLE_FREQUENCY, default 10000000: sample strobe rate in Hz; DIV = CLK_FREQUENCY/SAMPLE_FREQUENCY SHALL be an integer >= 2.
- REQ-003 Parameter NUM_INPUTS, default 14: number of antenna pulse inputs.
- REQ-004 Parameter SAMPLES_PER_INTEGRATION, default 1000000: samples per integration window, >= 1.
- REQ-005 Parameter INVERT_INPUTS, default 1: 1 inverts pulse_in after synchronisation (inputs are active-low at the pins).
- REQ-006 clki  input  1: single system clock; all logic on its rising edge.
- REQ-007 rst  input  1: synchronous, active-high reset.
- REQ-008 enable  input  1: run control; low holds the block idle.
- REQ-009 pulse_in  input  NUM_INPUTS: asynchronous pulse inputs.
- REQ-010 sample_bits  output  NUM_INPUTS: captured sample word for the correlator core.
- REQ-011 sample_valid  output  1: one-cycle qualifier for sample_bits.
- REQ-012 sample_clk_pulse  output  1: one-cycle sample strobe, also routed to a pin.
- REQ-013 integration_clk_pulse  output  1: one-cycle end-of-window strobe, also routed to a pin.

Function
- REQ-014 Each pulse_in bit SHALL pass through a 2-flop synchroniser before any other use, then be inverted when INVERT_INPUTS=1.
- REQ-015 Divider counter SHALL count 0..DIV-1 while enable=1 and wrap to 0; sample_clk_pulse SHALL be high exactly in cycles where the counter equals DIV-1.
- REQ-016 In a sample_clk_pulse cycle the conditioned input vector SHALL be registered into sample_bits; sample_valid SHALL be high the following cycle only.
- REQ-017 sample_bits SHALL hold its value between samples.
- REQ-018 Sample counter SHALL count 0..SAMPLES_PER_INTEGRATION-1 on each sample_clk_pulse and wrap to 0.
- REQ-019 integration_clk_pulse SHALL be high coincident with the sample_valid of the last sample of a window (sample count SAMPLES_PER_INTEGRATION-1), one cycle wide.
- REQ-020 Counter widths SHALL be $clog2 of their modulus, minimum 1 bit; no overflow past the terminal value.
- REQ-021 enable=0 SHALL clear both counters and suppress all strobes and sample_valid the next cycle; sample_bits holds.
- REQ-022 enable deasserted mid-window SHALL discard the partial window: no integration_clk_pulse for it; next enable starts a fresh window at count 0.
- REQ-023 A sample_valid/integration_clk_pulse pending at enable fall SHALL still be issued (the one-cycle pipeline drains).
- REQ-024 Latency pin-to-sample_bits: 2 synchroniser cycles plus wait to next strobe plus 1 register cycle.

Reset
- REQ-025 rst=1 SHALL clear synchronisers, counters, sample_bits (all 0), sample_valid, sample_clk_pulse and integration_clk_pulse to 0; rst dominates enable.
- REQ-026 After rst falls with enable=1, first sample_clk_pulse SHALL occur DIV cycles later.

Configuration
- REQ-027 Macro SAMPLER_GLITCH_FILTER_EN defined: a third synchroniser stage is added and each bit is the 2-of-3 majority of the last three synchronised values; pin-to-sample latency grows by 1 cycle.
- REQ-028 Macro undefined: no filter; plain 2-flop synchroniser output is used.

Structure
- REQ-029 Shared package correlator_pkg SHALL hold default CLK_FREQUENCY, NUM_INPUTS and a sample-vector typedef sized by NUM_INPUTS.
- REQ-030 Synchroniser (plus optional filter) SHALL be one sub-module, pulse_sync, instantiated once with NUM_INPUTS width.

Verification (DIV=5, SAMPLES_PER_INTEGRATION=4, NUM_INPUTS=14, INVERT_INPUTS=1)
- REQ-031 Reset release, enable=1 -> sample_clk_pulse at cycles 5,10,15,...; sample_valid one cycle after each; all outputs 0 during rst.
- REQ-032 pulse_in=14'h3FFE held -> sample_bits=14'h0001 after first valid sample (inversion).
- REQ-033 Run 8 samples -> integration_clk_pulse exactly with the 4th and 8th sample_valid.
- REQ-034 enable dropped after 2 samples, raised 3 cycles later -> no integration pulse; next integration pulse with the 4th sample after re-enable.
- REQ-035 1-cycle glitch on pulse_in[3] between strobes, macro defined -> sample_bits[3] unchanged; macro undefined, glitch aligned to capture -> bit changes.
- REQ-036 rst asserted for one cycle mid-window -> all outputs 0 next cycle; counting restarts from 0.

Source files
------------

// File: rtl/correlator_pkg.sv
// correlator_pkg: shared defaults, sample-vector type and counter sizing helper for the correlator front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package correlator_pkg;

    localparam int DEFAULT_CLK_FREQUENCY = 50_000_000;
    localparam int DEFAULT_NUM_INPUTS    = 14;

    // One bit per antenna input, as delivered to the correlator core.
    typedef logic [DEFAULT_NUM_INPUTS-1:0] sample_vec_t;

    // Width of a counter that runs 0..modulus-1; never narrower than one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// pulse_sync: 2-flop synchroniser per bit; with SAMPLER_GLITCH_FILTER_EN a 2-of-3 majority over the last three synchronised values.
// Latency: 2 cycles pin to dout (3 cycles with SAMPLER_GLITCH_FILTER_EN).
// Backpressure: none; free-running every clock.
module pulse_sync
    import correlator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_NUM_INPUTS
) (
    input  logic             clki,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Two-stage synchroniser; sync1_q may go metastable and is never used elsewhere.
    always_ff @(posedge clki) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

`ifdef SAMPLER_GLITCH_FILTER_EN
    logic [WIDTH-1:0] hist1_q;
    logic [WIDTH-1:0] hist2_q;

    // History of the synchronised value so a single-cycle excursion is outvoted.
    always_ff @(posedge clki) begin
        if (rst) begin
            hist1_q <= '0;
            hist2_q <= '0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    assign dout = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
    assign dout = sync2_q;
`endif

endmodule

// File: rtl/input_sampler.sv
// input_sampler: conditions antenna pulse inputs and captures them on a divided sample strobe, flagging each integration window end.
// Latency: pin to sample_bits = 2 sync cycles (+1 with SAMPLER_GLITCH_FILTER_EN) + wait to next strobe + 1 register cycle.
// Backpressure: none; enable low clears counters and idles strobes, sample_bits holds its last value.
module input_sampler
    import correlator_pkg::*;
#(
    parameter int CLK_FREQUENCY           = DEFAULT_CLK_FREQUENCY,
    parameter int SAMPLE_FREQUENCY        = 10_000_000,
    parameter int NUM_INPUTS              = DEFAULT_NUM_INPUTS,
    parameter int SAMPLES_PER_INTEGRATION = 1_000_000,
    parameter int INVERT_INPUTS           = 1
) (
    input  logic                  clki,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_INPUTS-1:0] pulse_in,
    output logic [NUM_INPUTS-1:0] sample_bits,
    output logic                  sample_valid,
    output logic                  sample_clk_pulse,
    output logic                  integration_clk_pulse
);

    localparam int DIV   = CLK_FREQUENCY / SAMPLE_FREQUENCY;
    localparam int DIV_W = cnt_width(DIV);
    localparam int SPI_W = cnt_width(SAMPLES_PER_INTEGRATION);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV - 2);
    localparam logic [SPI_W-1:0] SPI_LAST = SPI_W'(SAMPLES_PER_INTEGRATION - 1);

    logic [NUM_INPUTS-1:0] sync_bits;
    logic [NUM_INPUTS-1:0] cond_bits;
    logic [DIV_W-1:0]      div_cnt;
    logic [SPI_W-1:0]      sample_cnt;

    pulse_sync #(
        .WIDTH (NUM_INPUTS)
    ) u_pulse_sync (
        .clki (clki),
        .rst  (rst),
        .din  (pulse_in),
        .dout (sync_bits)
    );

    // Pins are active-low on the board, so the correlator sees a 1 for an active pulse.
    assign cond_bits = (INVERT_INPUTS != 0) ? ~sync_bits : sync_bits;

    // Divider; the strobe register is loaded one count early so it is high exactly while div_cnt == DIV-1.
    always_ff @(posedge clki) begin
        if (rst || !enable) begin
            div_cnt          <= '0;
            sample_clk_pulse <= 1'b0;
        end else begin
            div_cnt          <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            sample_clk_pulse <= (div_cnt == DIV_PRE);
        end
    end

    // Window position; dropping enable throws away a partial window so the next run starts at zero.
    always_ff @(posedge clki) begin
        if (rst || !enable) begin
            sample_cnt <= '0;
        end else if (sample_clk_pulse) begin
            sample_cnt <= (sample_cnt == SPI_LAST) ? '0 : sample_cnt + 1'b1;
        end
    end

    // Capture stage; a strobe already in flight when enable falls still completes its capture and qualifiers.
    always_ff @(posedge clki) begin
        if (rst) begin
            sample_bits           <= '0;
            sample_valid          <= 1'b0;
            integration_clk_pulse <= 1'b0;
        end else begin
            sample_valid          <= sample_clk_pulse;
            integration_clk_pulse <= sample_clk_pulse && (sample_cnt == SPI_LAST);
            if (sample_clk_pulse) begin
                sample_bits <= cond_bits;
            end
        end
    end

endmodule

// File: tb/tb_input_sampler.sv
// tb_input_sampler: directed bench for input_sampler with DIV=5, 4 samples per window, 14 active-low inputs.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_input_sampler;
    import correlator_pkg::*;

    logic        clki = 1'b0;
    logic        rst;
    logic        enable;
    sample_vec_t pulse_in;
    sample_vec_t sample_bits;
    logic        sample_valid;
    logic        sample_clk_pulse;
    logic        integration_clk_pulse;

    int checks = 0;
    int errors = 0;

    input_sampler #(
        .CLK_FREQUENCY           (50_000_000),
        .SAMPLE_FREQUENCY        (10_000_000),
        .NUM_INPUTS              (14),
        .SAMPLES_PER_INTEGRATION (4),
        .INVERT_INPUTS           (1)
    ) dut (
        .clki                  (clki),
        .rst                   (rst),
        .enable                (enable),
        .pulse_in              (pulse_in),
        .sample_bits           (sample_bits),
        .sample_valid          (sample_valid),
        .sample_clk_pulse      (sample_clk_pulse),
        .integration_clk_pulse (integration_clk_pulse)
    );

    always #5 clki = ~clki;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Checks outputs cycle by cycle. r counts cycles from the cycle in which the counters start
    // from zero with enable high (r=1); strobe at r=5,10,...; valid one cycle later.
    // Entered at the negedge of cycle r_first, leaves at the negedge of cycle r_last+1.
    task automatic run_phase(input string tag, input int r_first, input int r_last,
                             input int icp_a, input int icp_b, input bit idle,
                             input logic [13:0] bits_init, input logic [13:0] bits_run);
        bit          exp_scp;
        bit          exp_vld;
        bit          exp_icp;
        logic [13:0] exp_bits;
        for (int r = r_first; r <= r_last; r++) begin
            exp_scp  = !idle && (r > 0) && (r % 5 == 0);
            exp_vld  = !idle && (r > 1) && (r % 5 == 1);
            exp_icp  = !idle && ((r == icp_a) || (r == icp_b));
            exp_bits = (r >= 6) ? bits_run : bits_init;
            check($sformatf("%s_scp_r%0d", tag, r), sample_clk_pulse, exp_scp);
            check($sformatf("%s_vld_r%0d", tag, r), sample_valid, exp_vld);
            check($sformatf("%s_icp_r%0d", tag, r), integration_clk_pulse, exp_icp);
            check($sformatf("%s_bits_r%0d", tag, r), sample_bits, exp_bits);
            @(negedge clki);
        end
    endtask

    // Advances until the chosen strobe is seen at a negedge, bounded by 12 cycles.
    task automatic wait_strobe(input string tag, input bit want_scp);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clki);
            if (want_scp ? sample_clk_pulse : sample_valid) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, found, 1'b1);
    endtask

    logic [13:0] pats     [3];
    logic [13:0] pats_exp [3];
    logic [13:0] glitch_exp;

    initial begin
        pats[0] = 14'h0000; pats_exp[0] = 14'h3FFF;
        pats[1] = 14'h2AAA; pats_exp[1] = 14'h1555;
        pats[2] = 14'h1234; pats_exp[2] = 14'h2DCB;
`ifdef SAMPLER_GLITCH_FILTER_EN
        glitch_exp = 14'h0001;
`else
        glitch_exp = 14'h0009;
`endif

        rst      = 1'b1;
        enable   = 1'b1;
        pulse_in = 14'h3FFE;
        repeat (3) @(negedge clki);
        check("rst_bits", sample_bits, 14'h0000);
        check("rst_vld", sample_valid, 1'b0);
        check("rst_scp", sample_clk_pulse, 1'b0);
        check("rst_icp", integration_clk_pulse, 1'b0);

        // Ten samples after release: windows close on the 4th and 8th valid.
        rst = 1'b0;
        run_phase("a", 1, 52, 21, 41, 1'b0, 14'h0000, 14'h0001);

        // One-cycle reset two samples into a window.
        rst = 1'b1;
        @(negedge clki);
        check("rstmid_bits", sample_bits, 14'h0000);
        check("rstmid_vld", sample_valid, 1'b0);
        check("rstmid_scp", sample_clk_pulse, 1'b0);
        check("rstmid_icp", integration_clk_pulse, 1'b0);
        rst = 1'b0;
        run_phase("c", 1, 31, 21, -99, 1'b0, 14'h0000, 14'h0001);

        // Two samples into a new window, enable low for 3 cycles.
        enable = 1'b0;
        run_phase("off", 32, 34, -99, -99, 1'b1, 14'h0001, 14'h0001);
        enable = 1'b1;
        run_phase("d", 1, 22, 21, -99, 1'b0, 14'h0001, 14'h0001);

        // Other input patterns; the second valid is well past the synchroniser.
        for (int p = 0; p < 3; p++) begin
            pulse_in = pats[p];
            wait_strobe($sformatf("pat%0d_wait1", p), 1'b0);
            wait_strobe($sformatf("pat%0d_wait2", p), 1'b0);
            check($sformatf("pat%0d_bits", p), sample_bits, pats_exp[p]);
        end

        // Single-cycle glitch on pin 3 timed to reach the synchroniser output in the strobe cycle.
        pulse_in = 14'h3FFE;
        wait_strobe("gl_wait1", 1'b0);
        wait_strobe("gl_wait2", 1'b0);
        check("gl_base_bits", sample_bits, 14'h0001);
        wait_strobe("gl_wait_scp", 1'b1);
        repeat (3) @(negedge clki);
        pulse_in[3] = 1'b0;
        @(negedge clki);
        pulse_in[3] = 1'b1;
        @(negedge clki);
        check("gl_scp_align", sample_clk_pulse, 1'b1);
        @(negedge clki);
        check("gl_vld", sample_valid, 1'b1);
        check("gl_bits", sample_bits, glitch_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
